mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Iterative shift-and-add multiplier implementing the RV32M multiply group (MUL, MULH, MULHSU, MULHU).
- Sits beside the combinational ALU and takes the same rs1/rs2 operands.
- Its result feeds the ALU result mux; the core stalls on busy.
- Computes one product bit per clock, so it is much smaller than an array multiplier.

Parameters:
N, 32, operand and result width in bits (N >= 4).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
op  input  2  00 MUL (low N bits), 01 MULH (signed x signed, high), 10 MULHSU (a signed x b unsigned, high), 11 MULHU (unsigned x unsigned, high)
a  input  N  multiplicand (rs1)
b  input  N  multiplier (rs2)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result becomes valid
result  output  N  registered result, held until next completion

Behaviour:
- One clock domain; all state changes on rising clk.
- Reset is synchronous, active-high. When reset is sampled high:
  - state = IDLE;
  - busy = 0, done = 0, result = 0;
  - the internal accumulator and counter are cleared.
- Reset wins over every other event, including mid-operation and same-edge start. The aborted operation produces no done.
- States: IDLE, RUN, FIN.
- IDLE:
  - busy = 0.
  - On an edge with start = 1 (edge E0): latch op, the sign flag and the magnitudes |a| and |b|, then go to RUN with counter = 0.
  - Sign flag = (a signed and a[N-1]) XOR (b signed and b[N-1]). a is signed for op 00/01/10; b is signed for op 00/01.
  - For MUL, signedness does not affect the low half; it is treated as signed x signed.
  - Magnitudes are N-bit unsigned. The magnitude of -2^(N-1) is 2^(N-1), which fits.
- RUN:
  - busy = 1 for exactly N cycles (edges E1..EN).
  - Each edge adds the multiplicand to the upper half of a 2N-bit accumulator if the current multiplier LSB is 1, then shifts right by one. The carry-out is retained (N+1-bit add).
  - counter increments each edge; at edge EN go to FIN.
- FIN:
  - busy = 1.
  - At edge E(N+1): negate the 2N-bit product (two's complement) if the sign flag is set.
  - result = low N bits for op 00, high N bits otherwise.
  - done = 1, go to IDLE.
- done:
  - High for exactly the one cycle after E(N+1); cleared on the next edge.
  - Total latency: start-sampling edge to done = N+1 cycles.
- start:
  - Ignored while busy = 1.
  - Operands and op changing after E0 have no effect on the in-flight result.
- Back-to-back: start = 1 in the done cycle (state IDLE) is accepted. done falls and busy rises on that same edge.
- result changes only at FIN edges or reset; it is stable at all other times.
- Zero operands need no special case: they take full latency and return 0.

Test Plan:
- Reset: hold reset 2 cycles with start = 1 -> result = 0, busy = 0, done = 0; no operation starts.
- MUL 7 x 6 (N = 32), start at E0 -> busy high 33 cycles, done single pulse after E33, result = 0x0000002A. Change a/b during RUN -> still 0x2A.
- Sign cases:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000;
  - MUL same operands -> 0x00000000;
  - MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000;
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF;
  - MUL 0xFFFFFFFD x 5 -> 0xFFFFFFF1.
- Busy rules:
  - Pulse start with different operands 5 cycles into RUN -> ignored; result and latency unchanged.
  - Start asserted in the done cycle with 3 x 3 -> accepted; done after 33 more cycles with result = 9.
- Reset mid-operation: reset at cycle 10 of RUN -> next cycle busy = 0, no done pulse, result = 0. A new MULHU 0x10000 x 0x10000 then gives 0x00000001.

Source files
------------

// File: rtl/mul_seq.sv
// Iterative shift-and-add multiplier for the RV32M multiply group (MUL/MULH/MULHSU/MULHU).
// Works on operand magnitudes one multiplier bit per clock, then applies the sign in a final cycle.
module mul_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned W2 = 2 * N;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

  logic [1:0]    r_state, w_state_nx;
  logic [1:0]    r_op, w_op_nx;
  logic          r_neg, w_neg_nx;
  logic [N-1:0]  r_mcand, w_mcand_nx;
  logic [W2-1:0] r_acc, w_acc_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_busy, w_busy_nx;
  logic          r_done, w_done_nx;
  logic [N-1:0]  r_result, w_result_nx;

  logic          w_a_neg, w_b_neg;
  logic [N-1:0]  w_a_mag, w_b_mag;
  logic [N:0]    w_sum;
  logic [W2-1:0] w_prod;

  // a is signed for every op except MULHU; b only for MUL/MULH
  assign w_a_neg = (op != OP_MULHU) & a[N-1];
  assign w_b_neg = ~op[1] & b[N-1];
  assign w_a_mag = w_a_neg ? (~a + N'(1)) : a;
  assign w_b_mag = w_b_neg ? (~b + N'(1)) : b;

  // Carry-out kept so the partial product never overflows the upper half
  assign w_sum  = {1'b0, r_acc[W2-1:N]} + (r_acc[0] ? {1'b0, r_mcand} : {(N+1){1'b0}});
  assign w_prod = r_neg ? (~r_acc + W2'(1)) : r_acc;

  always_comb begin
    w_state_nx  = r_state;
    w_op_nx     = r_op;
    w_neg_nx    = r_neg;
    w_mcand_nx  = r_mcand;
    w_acc_nx    = r_acc;
    w_cnt_nx    = r_cnt;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_result_nx = r_result;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_op_nx    = op;
          w_neg_nx   = w_a_neg ^ w_b_neg;
          w_mcand_nx = w_a_mag;
          w_acc_nx   = {{N{1'b0}}, w_b_mag};
          w_cnt_nx   = '0;
          w_busy_nx  = 1'b1;
        end
      end
      S_RUN: begin
        w_acc_nx = {w_sum, r_acc[N-1:1]};
        w_cnt_nx = r_cnt + CW'(1);
        if (r_cnt == CW'(N - 1)) begin
          w_state_nx = S_FIN;
        end
      end
      S_FIN: begin
        w_result_nx = (r_op == OP_MUL) ? w_prod[N-1:0] : w_prod[W2-1:N];
        w_done_nx   = 1'b1;
        w_busy_nx   = 1'b0;
        w_state_nx  = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_op     <= w_op_nx;
      r_neg    <= w_neg_nx;
      r_mcand  <= w_mcand_nx;
      r_acc    <= w_acc_nx;
      r_cnt    <= w_cnt_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_result <= w_result_nx;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq (N = 32): latency, busy/done timing, signed variants, reset behaviour.
module tb_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  mul_seq #(.N(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents a request for one edge (E0), returns at the negedge after E0
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advances until done is seen (bounded); lat counts edges since E0, nb counts busy-high samples
  task automatic wait_done(inout int lat, inout int nb);
    while (!done && lat < 100) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
    int lat;
    int nb;
    launch(o, x, y);
    lat = 1;
    nb  = 0;
    lat = 0;
    wait_done(lat, nb);
    check({tag, " latency"}, 64'(lat), 64'd33);
    check({tag, " result"}, 64'(result), 64'(exp));
    @(negedge clk);
    check({tag, " done cleared"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int nb;
    int n_done;

    // Reset held with start asserted: nothing may start
    reset = 1'b1;
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd7;
    b     = 32'd6;
    repeat (2) @(negedge clk);
    check("reset result", 64'(result), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post-reset busy", 64'(busy), 64'd0);

    // MUL 7 x 6 with operands disturbed during RUN
    launch(2'b00, 32'd7, 32'd6);
    a   = 32'h1234_5678;
    b   = 32'h0BAD_F00D;
    op  = 2'b11;
    lat = 0;
    nb  = 0;
    wait_done(lat, nb);
    check("mul7x6 latency", 64'(lat), 64'd33);
    check("mul7x6 busy cycles", 64'(nb), 64'd33);
    check("mul7x6 result", 64'(result), 64'h2A);
    check("mul7x6 busy at done", 64'(busy), 64'd0);
    @(negedge clk);
    check("mul7x6 done pulse", 64'(done), 64'd0);
    check("mul7x6 result held", 64'(result), 64'h2A);

    // Sign handling
    run_op("mulh min*min",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mul min*min",    2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    run_op("mulh -1*-1",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhu max*max",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu -1*max",  2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul -3*5",       2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1);
    run_op("mul zero",       2'b00, 32'd0,         32'hDEAD_BEEF, 32'h0000_0000);

    // Start pulse 5 cycles into RUN must be ignored
    launch(2'b00, 32'd100, 32'd3);
    lat = 0;
    nb  = 0;
    repeat (5) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    start = 1'b1;
    op    = 2'b11;
    a     = 32'hFFFF_FFFF;
    b     = 32'hFFFF_FFFF;
    if (busy) nb++;
    @(negedge clk);
    lat++;
    start = 1'b0;
    wait_done(lat, nb);
    check("ignored start latency", 64'(lat), 64'd33);
    check("ignored start busy cycles", 64'(nb), 64'd33);
    check("ignored start result", 64'(result), 64'd300);

    // Back-to-back: start in the done cycle is accepted
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b done falls", 64'(done), 64'd0);
    check("b2b busy rises", 64'(busy), 64'd1);
    check("b2b old result held", 64'(result), 64'd300);
    lat = 0;
    nb  = 0;
    wait_done(lat, nb);
    check("b2b latency", 64'(lat), 64'd33);
    check("b2b result", 64'(result), 64'd9);
    @(negedge clk);

    // Reset in the middle of RUN aborts silently
    launch(2'b00, 32'd11, 32'd13);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort result", 64'(result), 64'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'd0);
    check("abort idle busy", 64'(busy), 64'd0);
    run_op("mulhu 2^16*2^16", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
